vga_pattern_gen: RTL
====================

VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 The module SHALL have parameter COLOR_W, default 4, giving the width of each colour channel.
REQ-002 The module SHALL have parameter NUM_COLORS, default 8, giving the number of palette entries (range 2..8).
REQ-003 The module SHALL have parameter PIX_DIV, default 2, giving the number of CLK50MHZ cycles per pixel (>=1).
REQ-004 The module SHALL have parameter DEB_CYCLES, default 500_000, giving the number of clocks a synchronised button level must be stable before it is accepted.
REQ-005 The module SHALL have parameter H_VIS, default 640, giving visible pixels per line (a multiple of 8).
REQ-006 The module SHALL have parameter H_FP, default 16, giving the horizontal front porch in pixels.
REQ-007 The module SHALL have parameter H_SYNC, default 96, giving the horizontal sync width in pixels.
REQ-008 The module SHALL have parameter H_BP, default 48, giving the horizontal back porch in pixels.
REQ-009 The module SHALL have parameter V_VIS, default 480, giving visible lines per frame.
REQ-010 The module SHALL have parameter V_FP, default 10, giving the vertical front porch in lines.
REQ-011 The module SHALL have parameter V_SYNC, default 2, giving the vertical sync width in lines.
REQ-012 The module SHALL have parameter V_BP, default 33, giving the vertical back porch in lines.
REQ-013 The module SHALL have port CLK50MHZ, input, 1 bit: the single clock; all logic uses its rising edge.
REQ-014 The module SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-015 The module SHALL have port BTN_NEXT, input, 1 bit: raw, asynchronous button that steps the palette forward.
REQ-016 The module SHALL have port BTN_PREV, input, 1 bit: raw, asynchronous button that steps the palette backward.
REQ-017 The module SHALL have ports VGA_R, VGA_G and VGA_B, each an output of COLOR_W bits carrying the registered pixel colour.
REQ-018 The module SHALL have ports VGA_HSYNC and VGA_VSYNC, each a 1-bit output carrying the registered sync, active-low.

Function
REQ-019 The module SHALL generate a pixel enable once every PIX_DIV clocks from a divider counter that wraps at PIX_DIV-1.
REQ-020 On each pixel enable, h_cnt SHALL count 0..H_TOTAL-1, where H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP; on h_cnt wrap, v_cnt SHALL count 0..V_TOTAL-1, computed the same way from the V_* parameters.
REQ-021 VGA_HSYNC SHALL be low when H_VIS+H_FP <= h_cnt < H_VIS+H_FP+H_SYNC, else high; VGA_VSYNC SHALL follow the same rule using v_cnt and the V_* parameters.
REQ-022 All outputs SHALL be registered on the pixel-enable clock edge, aligned to the same (h_cnt, v_cnt), with a latency of exactly one pixel enable.
REQ-023 Outside the visible area (h_cnt >= H_VIS or v_cnt >= V_VIS), VGA_R, VGA_G and VGA_B SHALL be 0.
REQ-024 Inside the visible area, colour index c SHALL drive VGA_R to all-ones if c[2] is set, VGA_G to all-ones if c[1] is set and VGA_B to all-ones if c[0] is set; each channel is otherwise 0.
REQ-025 Each button SHALL pass through a 2-flip-flop synchroniser followed by a debouncer that updates its accepted level only after the synchronised level has differed from it for DEB_CYCLES consecutive clocks.
REQ-026 A 0->1 transition of an accepted level SHALL set a pending step (next or prev); a later step SHALL override an earlier one, and steps detected in the same cycle on both buttons SHALL leave the pending step unchanged.
REQ-027 The pending step SHALL be applied only on the pixel enable where h_cnt=0 and v_cnt=0, and then cleared, so that no frame tears.
REQ-028 A next step SHALL increment the colour index and a prev step SHALL decrement it, wrapping between LAST and 0 in both directions (LAST defined in REQ-031/REQ-032).

Reset
REQ-029 While RST is high, and immediately on its assertion, the divider, h_cnt, v_cnt, colour index, pending step, synchronisers, debounce counters and accepted levels SHALL be 0, VGA_R/G/B SHALL be 0, and VGA_HSYNC and VGA_VSYNC SHALL be 1.
REQ-030 After RST is released mid-frame, timing SHALL restart from h_cnt=0, v_cnt=0 with no partial line.

Configuration
REQ-031 When VGA_BARS_EN is defined, LAST SHALL be NUM_COLORS, and index NUM_COLORS SHALL display 8 vertical bars, each H_VIS/8 pixels wide, with bar k coloured per REQ-024 using c=k.
REQ-032 When VGA_BARS_EN is not defined, LAST SHALL be NUM_COLORS-1 and no bar logic SHALL be present.

Verification
REQ-033 The bench SHALL release reset with default parameters and check: VGA_HSYNC period 32.0 us with a 3.84 us low pulse; VGA_VSYNC period 16.8 ms with a 64.0 us low pulse; the first low HSYNC begins 656 pixels after reset release.
REQ-034 The bench SHALL check that after reset the visible RGB is 0/0/0, and that holding BTN_NEXT longer than DEB_CYCLES gives RGB 0/0/F from the next frame start onward.
REQ-035 The bench SHALL toggle BTN_NEXT as glitches shorter than DEB_CYCLES and check that the colour index is unchanged across 3 frames.
REQ-036 The bench SHALL press BTN_PREV at index 0 and check RGB F/F/F (index 7) without VGA_BARS_EN, or bars with pixel 0 at 0/0/0 and pixel 560 at F/F/F with it.
REQ-037 The bench SHALL press BTN_NEXT and BTN_PREV with synchronous edges in the same cycle and check that the index stays at its prior value.
REQ-038 The bench SHALL assert RST at v_cnt=200 and check that all outputs reach their reset values within the same cycle, and that HSYNC goes low 656 pixels after release.

Source files
------------

// File: rtl/vga_pattern_gen.sv
`timescale 1ns/1ps
// vga_pattern_gen: VGA timing generator with a button-selected solid colour.
// Two debounced buttons step a colour index forward/backward. A step is held
// pending until the first pixel of the next frame, so a frame never tears.
// Optional feature macro VGA_BARS_EN adds one extra index after the palette
// that shows 8 vertical colour bars.
// Pending-step handshake: a debounced rising level is a one-cycle request. It
// is captured into the pending state with no back-pressure. The pending state
// is consumed and cleared on the pixel enable at (h_cnt=0, v_cnt=0).
module vga_pattern_gen #(
  parameter int COLOR_W    = 4,
  parameter int NUM_COLORS = 8,
  parameter int PIX_DIV    = 2,
  parameter int DEB_CYCLES = 500_000,
  parameter int H_VIS      = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VIS      = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33
) (
  input  logic               CLK50MHZ,
  input  logic               RST,
  input  logic               BTN_NEXT,
  input  logic               BTN_PREV,
  output logic [COLOR_W-1:0] VGA_R,
  output logic [COLOR_W-1:0] VGA_G,
  output logic [COLOR_W-1:0] VGA_B,
  output logic               VGA_HSYNC,
  output logic               VGA_VSYNC
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  // One spare count of headroom so the sync end bound always fits.
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int DEB_W   = $clog2(DEB_CYCLES + 1);
`ifdef VGA_BARS_EN
  localparam int IDX_W   = 4;
  localparam int LAST    = NUM_COLORS;
  localparam int BAR_W   = H_VIS / 8;
`else
  localparam int IDX_W   = 3;
  localparam int LAST    = NUM_COLORS - 1;
`endif

  localparam logic [HW-1:0]    H_LAST_C   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]    H_VIS_C    = HW'(H_VIS);
  localparam logic [HW-1:0]    HS_BEG_C   = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0]    HS_END_C   = HW'(H_VIS + H_FP + H_SYNC);
  localparam logic [VW-1:0]    V_LAST_C   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]    V_VIS_C    = VW'(V_VIS);
  localparam logic [VW-1:0]    VS_BEG_C   = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0]    VS_END_C   = VW'(V_VIS + V_FP + V_SYNC);
  localparam logic [DIV_W-1:0] DIV_LAST_C = DIV_W'(PIX_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST_C = DEB_W'(DEB_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_C     = IDX_W'(LAST);

  typedef enum logic [1:0] {
    PEND_NONE = 2'd0,
    PEND_NEXT = 2'd1,
    PEND_PREV = 2'd2
  } pend_t;

  logic [DIV_W-1:0] r_div;
  logic [HW-1:0]    r_h;
  logic [VW-1:0]    r_v;
  logic [1:0]       r_sync1;   // bit 0 = next, bit 1 = prev
  logic [1:0]       r_sync2;
  logic [1:0]       r_acc;
  logic [DEB_W-1:0] r_deb [2];
  pend_t            r_pend;
  pend_t            w_pend_next;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_step;
  logic [IDX_W-1:0] w_idx_eff;
  logic [1:0]       w_rise;
  logic [2:0]       w_c;
  logic             w_pix_en;
  logic             w_h_wrap;
  logic             w_v_wrap;
  logic             w_frame_pos;
  logic             w_vis;
  logic             w_hs;
  logic             w_vs;

  assign w_pix_en    = (r_div == DIV_LAST_C);
  assign w_h_wrap    = (r_h == H_LAST_C);
  assign w_v_wrap    = (r_v == V_LAST_C);
  assign w_frame_pos = (r_h == '0) && (r_v == '0);

  // Pixel-rate divider: wraps at PIX_DIV-1, enable on the wrap count.
  always_ff @(posedge CLK50MHZ or posedge RST) begin
    if (RST)           r_div <= '0;
    else if (w_pix_en) r_div <= '0;
    else               r_div <= r_div + 1'b1;
  end

  // Horizontal/vertical position counters, advanced once per pixel.
  always_ff @(posedge CLK50MHZ or posedge RST) begin
    if (RST) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_pix_en) begin
      if (w_h_wrap) begin
        r_h <= '0;
        r_v <= w_v_wrap ? '0 : r_v + 1'b1;
      end else begin
        r_h <= r_h + 1'b1;
      end
    end
  end

  // Button synchronisers and debouncers: accept a level after it has
  // differed from the accepted level for DEB_CYCLES consecutive clocks.
  always_ff @(posedge CLK50MHZ or posedge RST) begin
    if (RST) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_acc   <= '0;
      for (int i = 0; i < 2; i++) r_deb[i] <= '0;
    end else begin
      r_sync1 <= {BTN_PREV, BTN_NEXT};
      r_sync2 <= r_sync1;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] != r_acc[i]) begin
          if (r_deb[i] == DEB_LAST_C) begin
            r_acc[i] <= r_sync2[i];
            r_deb[i] <= '0;
          end else begin
            r_deb[i] <= r_deb[i] + 1'b1;
          end
        end else begin
          r_deb[i] <= '0;
        end
      end
    end
  end

  // Accepted-level 0->1 detection, one cycle wide, on the accepting clock.
  always_comb begin
    w_rise = '0;
    for (int i = 0; i < 2; i++)
      w_rise[i] = r_sync2[i] && !r_acc[i] && (r_deb[i] == DEB_LAST_C);
  end

  // Pending-step state register.
  always_ff @(posedge CLK50MHZ or posedge RST) begin
    if (RST) r_pend <= PEND_NONE;
    else     r_pend <= w_pend_next;
  end

  // Pending-step next state: cleared at frame start, newest step wins,
  // simultaneous steps on both buttons leave it alone.
  always_comb begin
    w_pend_next = r_pend;
    if (w_pix_en && w_frame_pos) w_pend_next = PEND_NONE;
    if (w_rise[0] && !w_rise[1])      w_pend_next = PEND_NEXT;
    else if (w_rise[1] && !w_rise[0]) w_pend_next = PEND_PREV;
  end

  // Index after applying the pending step, wrapping between LAST and 0.
  always_comb begin
    w_idx_step = r_idx;
    case (r_pend)
      PEND_NEXT: w_idx_step = (r_idx == LAST_C) ? '0 : r_idx + 1'b1;
      PEND_PREV: w_idx_step = (r_idx == '0) ? LAST_C : r_idx - 1'b1;
      default:   w_idx_step = r_idx;
    endcase
  end

  // Colour index register, updated only on the first pixel of a frame.
  always_ff @(posedge CLK50MHZ or posedge RST) begin
    if (RST)                          r_idx <= '0;
    else if (w_pix_en && w_frame_pos) r_idx <= w_idx_step;
  end

  // Pixel (0,0) already uses the new index so the whole frame matches.
  always_comb begin
    w_idx_eff = w_frame_pos ? w_idx_step : r_idx;
    w_vis     = (r_h < H_VIS_C) && (r_v < V_VIS_C);
    w_hs      = !((r_h >= HS_BEG_C) && (r_h < HS_END_C));
    w_vs      = !((r_v >= VS_BEG_C) && (r_v < VS_END_C));
`ifdef VGA_BARS_EN
    w_c       = (w_idx_eff == LAST_C) ? 3'(r_h / HW'(BAR_W)) : w_idx_eff[2:0];
`else
    w_c       = w_idx_eff;
`endif
  end

  // Registered outputs, one pixel enable behind the counters.
  always_ff @(posedge CLK50MHZ or posedge RST) begin
    if (RST) begin
      VGA_R     <= '0;
      VGA_G     <= '0;
      VGA_B     <= '0;
      VGA_HSYNC <= 1'b1;
      VGA_VSYNC <= 1'b1;
    end else if (w_pix_en) begin
      VGA_R     <= (w_vis && w_c[2]) ? {COLOR_W{1'b1}} : '0;
      VGA_G     <= (w_vis && w_c[1]) ? {COLOR_W{1'b1}} : '0;
      VGA_B     <= (w_vis && w_c[0]) ? {COLOR_W{1'b1}} : '0;
      VGA_HSYNC <= w_hs;
      VGA_VSYNC <= w_vs;
    end
  end

endmodule
